// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: turns PS/2 key events into per-voice pitch and ADSR-style envelope levels.
// Optional build macro VOICE_ALLOCATOR_STEAL_EN enables round-robin voice stealing when every voice is busy.
module voice_allocator #(
    parameter int NUM_VOICES   = 8,
    parameter int TICK_DIV     = 24000,
    parameter int ATTACK_STEP  = 2048,
    parameter int RELEASE_STEP = 512,
    parameter int VOL_MAX      = 65535
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [10:0]                  ps2_key,
    output logic [NUM_VOICES-1:0][31:0]  frequencies,
    output logic [NUM_VOICES-1:0][31:0]  voice_volumes,
    output logic [NUM_VOICES-1:0]        active_mask,
    output logic                         overflow
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } voice_state_t;

    // Returns {valid, note index}; index 0 is C4 and 12 is C5.
    function automatic logic [4:0] noteLookup(input logic [7:0] code);
        logic [4:0] res;
        case (code)
            8'h1C:   res = {1'b1, 4'd0};
            8'h1D:   res = {1'b1, 4'd1};
            8'h1B:   res = {1'b1, 4'd2};
            8'h24:   res = {1'b1, 4'd3};
            8'h23:   res = {1'b1, 4'd4};
            8'h2B:   res = {1'b1, 4'd5};
            8'h2C:   res = {1'b1, 4'd6};
            8'h34:   res = {1'b1, 4'd7};
            8'h35:   res = {1'b1, 4'd8};
            8'h33:   res = {1'b1, 4'd9};
            8'h3C:   res = {1'b1, 4'd10};
            8'h3B:   res = {1'b1, 4'd11};
            8'h42:   res = {1'b1, 4'd12};
            default: res = 5'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] noteFreq(input logic [3:0] idx);
        logic [31:0] f;
        case (idx)
            4'd0:    f = 32'd66977;
            4'd1:    f = 32'd70959;
            4'd2:    f = 32'd75178;
            4'd3:    f = 32'd79649;
            4'd4:    f = 32'd84385;
            4'd5:    f = 32'd89402;
            4'd6:    f = 32'd94719;
            4'd7:    f = 32'd100351;
            4'd8:    f = 32'd106318;
            4'd9:    f = 32'd112640;
            4'd10:   f = 32'd119338;
            4'd11:   f = 32'd126434;
            4'd12:   f = 32'd133952;
            default: f = 32'd0;
        endcase
        return f;
    endfunction

    logic                 r_started;
    logic                 r_togglePrev;
    logic                 r_evtValid;
    logic                 r_evtPress;
    logic [3:0]           r_evtNote;
    logic [CNT_W-1:0]     r_tickCnt;
    logic                 r_overflow;
    voice_state_t         r_state [NUM_VOICES];
    logic [15:0]          r_vol   [NUM_VOICES];
    logic [31:0]          r_freq  [NUM_VOICES];
    logic [3:0]           r_note  [NUM_VOICES];
`ifdef VOICE_ALLOCATOR_STEAL_EN
    logic [VIDX_W-1:0]    r_stealPtr;
    logic [VIDX_W-1:0]    w_stealPtrNext;
    logic [NUM_VOICES-1:0] w_stealMask;
`endif

    logic [4:0]            w_lookup;
    logic                  w_tick;
    logic [NUM_VOICES-1:0] w_held;
    logic [NUM_VOICES-1:0] w_releasing;
    logic [NUM_VOICES-1:0] w_idle;
    logic [NUM_VOICES-1:0] w_retrigMask;
    logic [NUM_VOICES-1:0] w_allocMask;
    logic                  w_isPress;
    logic                  w_doRelease;
    logic                  w_doRetrig;
    logic                  w_doAlloc;
    logic                  w_noVoice;
    logic                  w_dropped;
    voice_state_t          w_nextState [NUM_VOICES];
    logic [15:0]           w_nextVol   [NUM_VOICES];
    logic [31:0]           w_nextFreq  [NUM_VOICES];
    logic [3:0]            w_nextNote  [NUM_VOICES];

    assign w_lookup = noteLookup(ps2_key[7:0]);
    assign w_tick   = (r_tickCnt == CNT_W'(TICK_DIV - 1));

    // Event decode stage; the first clock after reset only samples the toggle bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_started    <= 1'b0;
            r_togglePrev <= 1'b0;
            r_evtValid   <= 1'b0;
            r_evtPress   <= 1'b0;
            r_evtNote    <= 4'd0;
        end else begin
            r_started    <= 1'b1;
            r_togglePrev <= ps2_key[10];
            r_evtValid   <= r_started && (ps2_key[10] != r_togglePrev) && !ps2_key[8] && w_lookup[4];
            r_evtPress   <= ps2_key[9];
            r_evtNote    <= w_lookup[3:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    always_comb begin
        w_held      = '0;
        w_releasing = '0;
        w_idle      = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_held[i]      = (r_note[i] == r_evtNote) && ((r_state[i] == ATTACK) || (r_state[i] == SUSTAIN));
            w_releasing[i] = (r_note[i] == r_evtNote) && (r_state[i] == RELEASE);
            w_idle[i]      = (r_state[i] == IDLE);
        end
    end

    // Lowest-set-bit isolation picks the lowest-numbered candidate voice.
    assign w_retrigMask = w_releasing & (~w_releasing + NUM_VOICES'(1));
    assign w_allocMask  = w_idle & (~w_idle + NUM_VOICES'(1));
    assign w_isPress    = r_evtValid && r_evtPress && !(|w_held);
    assign w_doRelease  = r_evtValid && !r_evtPress;
    assign w_doRetrig   = w_isPress && (|w_releasing);
    assign w_doAlloc    = w_isPress && !(|w_releasing) && (|w_idle);
    assign w_noVoice    = w_isPress && !(|w_releasing) && !(|w_idle);

`ifdef VOICE_ALLOCATOR_STEAL_EN
    assign w_stealMask    = NUM_VOICES'(1) << r_stealPtr;
    assign w_stealPtrNext = !w_noVoice ? r_stealPtr :
                            (r_stealPtr == VIDX_W'(NUM_VOICES - 1)) ? '0 : r_stealPtr + 1'b1;
    assign w_dropped      = 1'b0;
`else
    assign w_dropped      = w_noVoice;
`endif

    // Event is applied first, then any tick in the same cycle acts on the post-event state.
    always_comb begin : nextVoice
        logic [16:0] w_attackSum;
        logic        w_load;
        w_attackSum = '0;
        w_load      = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_nextState[i] = r_state[i];
            w_nextVol[i]   = r_vol[i];
            w_nextFreq[i]  = r_freq[i];
            w_nextNote[i]  = r_note[i];

            w_load = w_doAlloc && w_allocMask[i];
`ifdef VOICE_ALLOCATOR_STEAL_EN
            w_load = w_load || (w_noVoice && w_stealMask[i]);
`endif
            if (w_doRelease && w_held[i]) begin
                w_nextState[i] = RELEASE;
            end
            if (w_doRetrig && w_retrigMask[i]) begin
                w_nextState[i] = ATTACK;
            end
            if (w_load) begin
                w_nextState[i] = ATTACK;
                w_nextVol[i]   = 16'd0;
                w_nextFreq[i]  = noteFreq(r_evtNote);
                w_nextNote[i]  = r_evtNote;
            end

            if (w_tick) begin
                case (w_nextState[i])
                    ATTACK: begin
                        w_attackSum = {1'b0, w_nextVol[i]} + 17'(ATTACK_STEP);
                        if (w_attackSum >= 17'(VOL_MAX)) begin
                            w_nextVol[i]   = 16'(VOL_MAX);
                            w_nextState[i] = SUSTAIN;
                        end else begin
                            w_nextVol[i]   = w_attackSum[15:0];
                        end
                    end
                    RELEASE: begin
                        if (w_nextVol[i] <= 16'(RELEASE_STEP)) begin
                            w_nextVol[i]   = 16'd0;
                            w_nextState[i] = IDLE;
                        end else begin
                            w_nextVol[i]   = w_nextVol[i] - 16'(RELEASE_STEP);
                        end
                    end
                    default: begin
                        w_nextVol[i] = w_nextVol[i];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_state[i] <= IDLE;
                r_vol[i]   <= 16'd0;
                r_freq[i]  <= 32'd0;
                r_note[i]  <= 4'd0;
            end
            r_overflow <= 1'b0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            r_stealPtr <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_state[i] <= w_nextState[i];
                r_vol[i]   <= w_nextVol[i];
                r_freq[i]  <= w_nextFreq[i];
                r_note[i]  <= w_nextNote[i];
            end
            r_overflow <= w_dropped;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            r_stealPtr <= w_stealPtrNext;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            frequencies[i]   = r_freq[i];
            voice_volumes[i] = {16'd0, r_vol[i]};
            active_mask[i]   = (r_state[i] != IDLE);
        end
    end

    assign overflow = r_overflow;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with a short envelope tick period.
// Checks latency, envelope ramps, retrigger, allocation limits, filtering and async reset.
module tb_voice_allocator;

    localparam int NV = 8;
    localparam int TD = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [10:0]          ps2_key;
    logic [NV-1:0][31:0]  frequencies;
    logic [NV-1:0][31:0]  voice_volumes;
    logic [NV-1:0]        active_mask;
    logic                 overflow;

    int checks = 0;
    int errors = 0;
    int tbCnt = 0;
    int tickCount = 0;

    logic [7:0] codes   [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
    int         expFreq [13] = '{66977, 70959, 75178, 79649, 84385, 89402, 94719,
                                 100351, 106318, 112640, 119338, 126434, 133952};

    voice_allocator #(
        .NUM_VOICES  (NV),
        .TICK_DIV    (TD),
        .ATTACK_STEP (2048),
        .RELEASE_STEP(512),
        .VOL_MAX     (65535)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_key      (ps2_key),
        .frequencies  (frequencies),
        .voice_volumes(voice_volumes),
        .active_mask  (active_mask),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference envelope timebase: a tick is applied on the edge where the count is TD-1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbCnt <= 0;
        end else if (tbCnt == TD - 1) begin
            tbCnt     <= 0;
            tickCount <= tickCount + 1;
        end else begin
            tbCnt <= tbCnt + 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendKey(input logic press, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], press, ext, code};
    endtask

    // Leaves us at a falling edge where the next two rising edges carry no tick.
    task automatic syncPhase();
        bit found;
        found = 0;
        for (int k = 0; k < TD + 4; k++) begin
            @(negedge clk);
            if (tbCnt == 0) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL sync_phase: got tbCnt=%0d required 0", tbCnt);
        end
    endtask

    task automatic waitTicks(input int n);
        int target;
        target = tickCount + n;
        for (int k = 0; k < (n + 2) * TD; k++) begin
            @(negedge clk);
            if (tickCount >= target) break;
        end
        checks++;
        if (tickCount < target) begin
            errors++;
            $display("[TB] FAIL wait_ticks: got %0d ticks required %0d", tickCount, target);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ps2_key = 11'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (active_mask !== 8'h00 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mask: got mask=%h ovf=%b required mask=00 ovf=0", active_mask, overflow);
        end
        checks++;
        if (frequencies !== '0 || voice_volumes !== '0) begin
            errors++;
            $display("[TB] FAIL reset_vectors: got freq=%h vol=%h required all zero", frequencies, voice_volumes);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (active_mask !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_idle_after: got mask=%h required 00", active_mask);
        end
    endtask

    task automatic test_attack();
        int t0;
        doReset();
        syncPhase();
        t0 = tickCount;
        sendKey(1'b1, 1'b0, 8'h33);
        @(negedge clk);
        checks++;
        if (active_mask !== 8'h00 || frequencies[0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL attack_early: got mask=%h freq0=%0d required mask=00 freq0=0", active_mask, frequencies[0]);
        end
        @(negedge clk);
        checks++;
        if (frequencies[0] !== 32'd112640 || active_mask !== 8'h01 || voice_volumes[0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL attack_start: got freq0=%0d mask=%h vol0=%0d required 112640 01 0",
                     frequencies[0], active_mask, voice_volumes[0]);
        end
        waitTicks(31 - (tickCount - t0));
        checks++;
        if (voice_volumes[0] !== 32'd63488) begin
            errors++;
            $display("[TB] FAIL attack_ramp31: got vol0=%0d required 63488", voice_volumes[0]);
        end
        waitTicks(1);
        checks++;
        if (voice_volumes[0] !== 32'd65535) begin
            errors++;
            $display("[TB] FAIL attack_peak: got vol0=%0d required 65535", voice_volumes[0]);
        end
        waitTicks(1);
        checks++;
        if (voice_volumes[0] !== 32'd65535 || active_mask !== 8'h01) begin
            errors++;
            $display("[TB] FAIL sustain_hold: got vol0=%0d mask=%h required 65535 01", voice_volumes[0], active_mask);
        end
    endtask

    task automatic test_release();
        doReset();
        syncPhase();
        sendKey(1'b1, 1'b0, 8'h1C);
        repeat (2) @(negedge clk);
        waitTicks(33);
        syncPhase();
        sendKey(1'b0, 1'b0, 8'h1C);
        repeat (2) @(negedge clk);
        checks++;
        if (voice_volumes[0] !== 32'd65535 || active_mask !== 8'h01) begin
            errors++;
            $display("[TB] FAIL release_start: got vol0=%0d mask=%h required 65535 01", voice_volumes[0], active_mask);
        end
        waitTicks(1);
        checks++;
        if (voice_volumes[0] !== 32'd65023) begin
            errors++;
            $display("[TB] FAIL release_step1: got vol0=%0d required 65023", voice_volumes[0]);
        end
        waitTicks(126);
        checks++;
        if (voice_volumes[0] !== 32'd511 || active_mask !== 8'h01) begin
            errors++;
            $display("[TB] FAIL release_tick127: got vol0=%0d mask=%h required 511 01", voice_volumes[0], active_mask);
        end
        waitTicks(1);
        checks++;
        if (voice_volumes[0] !== 32'd0 || active_mask !== 8'h00 || frequencies[0] !== 32'd66977) begin
            errors++;
            $display("[TB] FAIL release_idle: got vol0=%0d mask=%h freq0=%0d required 0 00 66977",
                     voice_volumes[0], active_mask, frequencies[0]);
        end
    endtask

    task automatic test_retrigger();
        int t0;
        int tR;
        int peak;
        int expV;
        doReset();
        syncPhase();
        t0 = tickCount;
        sendKey(1'b1, 1'b0, 8'h1C);
        repeat (2) @(negedge clk);
        syncPhase();
        sendKey(1'b1, 1'b0, 8'h1C);
        repeat (2) @(negedge clk);
        checks++;
        if (active_mask !== 8'h01 || frequencies[1] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL repress_held: got mask=%h freq1=%0d required 01 0", active_mask, frequencies[1]);
        end
        waitTicks(2);
        syncPhase();
        peak = (tickCount - t0) * 2048;
        tR = tickCount;
        sendKey(1'b0, 1'b0, 8'h1C);
        repeat (2) @(negedge clk);
        checks++;
        if (voice_volumes[0] !== 32'(peak)) begin
            errors++;
            $display("[TB] FAIL retrig_peak: got vol0=%0d required %0d", voice_volumes[0], peak);
        end
        waitTicks(3);
        checks++;
        if (voice_volumes[0] !== 32'(peak - 512 * (tickCount - tR))) begin
            errors++;
            $display("[TB] FAIL retrig_decay: got vol0=%0d required %0d", voice_volumes[0], peak - 512 * (tickCount - tR));
        end
        syncPhase();
        expV = peak - 512 * (tickCount - tR);
        sendKey(1'b1, 1'b0, 8'h1C);
        repeat (2) @(negedge clk);
        checks++;
        if (voice_volumes[0] !== 32'(expV) || active_mask !== 8'h01 || frequencies[1] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL retrig_keep: got vol0=%0d mask=%h freq1=%0d required %0d 01 0",
                     voice_volumes[0], active_mask, frequencies[1], expV);
        end
        waitTicks(1);
        checks++;
        if (voice_volumes[0] !== 32'(expV + 2048)) begin
            errors++;
            $display("[TB] FAIL retrig_attack: got vol0=%0d required %0d", voice_volumes[0], expV + 2048);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        syncPhase();
        sendKey(1'b1, 1'b0, 8'h1C);
        @(negedge clk);
        sendKey(1'b1, 1'b0, 8'h1D);
        @(negedge clk);
        checks++;
        if (active_mask !== 8'h01) begin
            errors++;
            $display("[TB] FAIL b2b_first: got mask=%h required 01", active_mask);
        end
        @(negedge clk);
        checks++;
        if (active_mask !== 8'h03 || frequencies[1] !== 32'd70959) begin
            errors++;
            $display("[TB] FAIL b2b_second: got mask=%h freq1=%0d required 03 70959", active_mask, frequencies[1]);
        end
    endtask

    task automatic test_full_voices();
        doReset();
        for (int i = 0; i < 8; i++) begin
            sendKey(1'b1, 1'b0, codes[i]);
            repeat (2) @(negedge clk);
        end
        checks++;
        if (active_mask !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL full_mask: got %h required FF", active_mask);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (frequencies[i] !== 32'(expFreq[i])) begin
                errors++;
                $display("[TB] FAIL full_freq%0d: got %0d required %0d", i, frequencies[i], expFreq[i]);
            end
        end
        syncPhase();
        sendKey(1'b1, 1'b0, codes[8]);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ninth_early_ovf: got %b required 0", overflow);
        end
        @(negedge clk);
`ifdef VOICE_ALLOCATOR_STEAL_EN
        checks++;
        if (overflow !== 1'b0 || frequencies[0] !== 32'd106318 || voice_volumes[0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL steal_voice0: got ovf=%b freq0=%0d vol0=%0d required 0 106318 0",
                     overflow, frequencies[0], voice_volumes[0]);
        end
`else
        checks++;
        if (overflow !== 1'b1 || frequencies[0] !== 32'd66977) begin
            errors++;
            $display("[TB] FAIL drop_pulse: got ovf=%b freq0=%0d required 1 66977", overflow, frequencies[0]);
        end
`endif
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || active_mask !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL ninth_after: got ovf=%b mask=%h required 0 FF", overflow, active_mask);
        end
`ifdef VOICE_ALLOCATOR_STEAL_EN
        syncPhase();
        sendKey(1'b1, 1'b0, codes[9]);
        repeat (2) @(negedge clk);
        checks++;
        if (frequencies[1] !== 32'd112640 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL steal_ptr1: got freq1=%0d ovf=%b required 112640 0", frequencies[1], overflow);
        end
`else
        checks++;
        if (frequencies[7] !== 32'd100351) begin
            errors++;
            $display("[TB] FAIL drop_keep7: got freq7=%0d required 100351", frequencies[7]);
        end
`endif
    endtask

    task automatic test_ignored();
        doReset();
        sendKey(1'b1, 1'b0, 8'h33);
        repeat (2) @(negedge clk);
        sendKey(1'b1, 1'b1, 8'h1C);
        repeat (3) @(negedge clk);
        checks++;
        if (active_mask !== 8'h01 || frequencies[1] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL ignore_ext: got mask=%h freq1=%0d required 01 0", active_mask, frequencies[1]);
        end
        sendKey(1'b1, 1'b0, 8'h76);
        repeat (3) @(negedge clk);
        checks++;
        if (active_mask !== 8'h01 || frequencies[1] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL ignore_unmapped: got mask=%h freq1=%0d required 01 0", active_mask, frequencies[1]);
        end
        ps2_key[9:0] = {1'b1, 1'b0, 8'h1C};
        repeat (3) @(negedge clk);
        checks++;
        if (active_mask !== 8'h01 || frequencies[1] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL ignore_notoggle: got mask=%h freq1=%0d required 01 0", active_mask, frequencies[1]);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        syncPhase();
        sendKey(1'b1, 1'b0, 8'h33);
        repeat (2) @(negedge clk);
        waitTicks(3);
        checks++;
        if (voice_volumes[0] !== 32'd6144) begin
            errors++;
            $display("[TB] FAIL midattack_vol: got vol0=%0d required 6144", voice_volumes[0]);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
        #1;
        checks++;
        if (active_mask !== 8'h00 || frequencies !== '0 || voice_volumes !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_clear: got mask=%h freq0=%0d vol0=%0d ovf=%b required all zero",
                     active_mask, frequencies[0], voice_volumes[0], overflow);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (active_mask !== 8'h00 || frequencies[0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL no_spurious: got mask=%h freq0=%0d required 00 0", active_mask, frequencies[0]);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ps2_key = 11'd0;
        $display("[TB] starting voice_allocator bench");
        test_reset();
        test_attack();
        test_release();
        test_retrigger();
        test_back_to_back();
        test_full_voices();
        test_ignored();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
